sort_engine: RTL and testbench
==============================

# sort_engine

Parametrised in-place bubble-sort engine with early termination and a shrinking pass bound. It accepts DEPTH words over a valid/ready load port, sorts them ascending or descending with one compare-swap per clock, then streams the result out over a valid/ready drain port. It is the generic successor to the fixed 8-entry sorter and plugs between a producer FIFO and a consumer in the data-ordering path.

## Interface
- WIDTH, 8: element width in bits, unsigned compare; must be 1 or greater.
- DEPTH, 8: number of elements; must be 2 or greater. PW = $clog2(DEPTH), SW = $clog2(DEPTH*(DEPTH-1)/2+1).
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  load word valid.
- in_data  in  WIDTH  load word; the first accepted word goes to slot 0.
- in_ready  out  1  high only in LOAD.
- desc  in  1  sort order: 0 = ascending, 1 = descending. Sampled on the last load transfer.
- out_valid  out  1  high only in DRAIN.
- out_data  out  WIDTH  slot[rd_ptr], starting at slot 0.
- out_ready  in  1  consumer accept.
- busy  out  1  high in SORT.
- done  out  1  one-cycle pulse in the first DRAIN cycle.
- swaps  out  SW  swaps performed in the current/last sort.
- passes  out  PW  passes completed in the current/last sort.

## Operation
- FSM states: LOAD, SORT, DRAIN.
- LOAD:
  - Each in_valid&in_ready writes slot[wr_ptr] and increments wr_ptr.
  - On the DEPTH-th transfer: latch desc, clear j, k, swaps, passes and swapped_in_pass, then go to SORT.
- SORT: each cycle compares slot[j] and slot[j+1].
  - The pair swaps if (ascending and slot[j] > slot[j+1]) or (descending and slot[j] < slot[j+1]). Equal elements never swap.
  - Every swap increments swaps and sets swapped_in_pass.
  - The inner index runs j = 0 .. DEPTH-2-k, where k is the pass index.
  - At j == DEPTH-2-k (end of pass), passes increments. The swapped-in-pass test includes the swap of this final cycle.
  - If no swap occurred in the pass, or k == DEPTH-2, go to DRAIN.
  - Otherwise k increments, j returns to 0, and swapped_in_pass clears.
- DRAIN:
  - Each out_valid&out_ready increments rd_ptr.
  - After the DEPTH-th transfer, go to LOAD with wr_ptr = rd_ptr = 0.
  - swaps and passes hold their values until the next SORT entry.
- in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.

## Timing
- Reset, sampled high: state LOAD, wr_ptr = rd_ptr = j = k = 0, all slots = 0.
  - Output values: in_ready = 1, out_valid = 0, out_data = 0, busy = 0, done = 0, swaps = 0, passes = 0.
- Reset mid-SORT or mid-DRAIN aborts the operation. The next cycle is LOAD with all of the above values.
- Load takes DEPTH accepted transfers. busy rises the cycle after the last transfer.
- SORT duration:
  - Best case (input already in order): DEPTH-1 cycles, 1 pass.
  - Worst case: DEPTH*(DEPTH-1)/2 cycles, DEPTH-1 passes.
- done and out_valid rise together in the first DRAIN cycle. out_data is valid in that same cycle.
- Drain with out_ready held high takes DEPTH cycles. in_ready rises the cycle after the last drain transfer.
- All outputs are decoded from registered state. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Shared package sort_pkg holds:
  - The state enum (LOAD/SORT/DRAIN).
  - Width helper functions for PW and SW.
- Sub-module sort_cmp_swap(WIDTH): purely combinational.
  - Inputs: a, b, desc.
  - Outputs: lo_out, hi_out, swap. In descending mode lo_out holds the larger value.
  - One instance reads slot[j] and slot[j+1].
- The storage array, pointers, counters and FSM live in sort_engine.

## Test plan
- WIDTH=8, DEPTH=8, desc=0, load 4,5,1,3,2,6,8,7:
  - Drain yields 1,2,3,4,5,6,7,8.
  - swaps = 8, passes = 4, busy high for exactly 22 cycles.
- Same data with desc=1:
  - Drain yields 8,7,6,5,4,3,2,1.
  - swaps = 20 (28 - 8).
- Already-sorted load 1..8, desc=0:
  - busy high for 7 cycles, passes = 1, swaps = 0.
- Reverse load 8..1, desc=0:
  - busy high for 28 cycles, passes = 7, swaps = 28.
- Duplicates 3,3,1,1,2,2,0,0 with out_ready toggled 1/0 every cycle:
  - Drain yields 0,0,1,1,2,2,3,3.
  - out_data holds its value while out_ready is low.
  - in_ready stays 0 until the 8th transfer completes.
- reset asserted on the 5th SORT cycle:
  - The next cycle shows in_ready=1, busy=0, swaps=0.
  - A fresh load of 2,1 (DEPTH=2 build) drains 1,2 with swaps = 1.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and width helpers for the bubble-sort engine.
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Pointer / pass-counter width for a given depth.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Swap-counter width: must hold the worst case depth*(depth-1)/2.
    function automatic int unsigned swap_w(input int unsigned depth);
        return $clog2(depth * (depth - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/sort_engine_if.sv
// Load and drain handshake bundle of the sort engine.
interface sort_engine_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             desc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, desc, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Engine side.
    modport slave (
        input  in_valid, in_data, desc, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sort_cmp_swap.sv
// Compare-exchange cell: lo_out is the element that belongs first in sort order.
module sort_cmp_swap #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             desc,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             swap
);
    // Equal elements never swap, keeping the sort stable.
    always_comb begin
        swap   = desc ? (a < b) : (a > b);
        lo_out = swap ? b : a;
        hi_out = swap ? a : b;
    end
endmodule

// File: rtl/sort_engine.sv
// In-place bubble sorter: load DEPTH words, sort one pair per clock, drain in order.
module sort_engine
    import sort_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    sort_engine_if.slave               bus,
    output logic                       busy,
    output logic                       done,
    output logic [swap_w(DEPTH)-1:0]   swaps,
    output logic [ptr_w(DEPTH)-1:0]    passes
);
    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned SW = swap_w(DEPTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, j, k, j1;
    logic             desc_q, swapped_in_pass;

    logic             in_fire, out_fire, load_last, drain_last;
    logic             pass_end, sort_stop;
    logic [WIDTH-1:0] lo_val, hi_val;
    logic             swap;

    assign j1         = j + PW'(1);
    assign in_fire    = bus.in_valid  && (state == LOAD);
    assign out_fire   = bus.out_ready && (state == DRAIN);
    assign load_last  = in_fire  && (wr_ptr == PW'(DEPTH - 1));
    assign drain_last = out_fire && (rd_ptr == PW'(DEPTH - 1));
    assign pass_end   = (j == (PW'(DEPTH - 2) - k));
    assign sort_stop  = pass_end && (!(swapped_in_pass || swap) || (k == PW'(DEPTH - 2)));
    assign bus.out_data = slots[rd_ptr];

    sort_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
        .a      (slots[j]),
        .b      (slots[j1]),
        .desc   (desc_q),
        .lo_out (lo_val),
        .hi_out (hi_val),
        .swap   (swap)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (load_last)  state_nxt = SORT;
            SORT:    if (sort_stop)  state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Status flags registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            bus.in_ready  <= (state_nxt == LOAD);
            bus.out_valid <= (state_nxt == DRAIN);
            busy          <= (state_nxt == SORT);
            done          <= (state == SORT) && (state_nxt == DRAIN);
        end
    end

    // Storage, pointers and sort counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) slots[i] <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            j               <= '0;
            k               <= '0;
            swaps           <= '0;
            passes          <= '0;
            desc_q          <= 1'b0;
            swapped_in_pass <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        slots[wr_ptr] <= bus.in_data;
                        wr_ptr        <= wr_ptr + PW'(1);
                    end
                    if (load_last) begin
                        wr_ptr          <= '0;
                        desc_q          <= bus.desc;
                        j               <= '0;
                        k               <= '0;
                        swaps           <= '0;
                        passes          <= '0;
                        swapped_in_pass <= 1'b0;
                    end
                end
                SORT: begin
                    if (swap) begin
                        slots[j]        <= lo_val;
                        slots[j1]       <= hi_val;
                        swaps           <= swaps + SW'(1);
                        swapped_in_pass <= 1'b1;
                    end
                    if (pass_end) begin
                        passes          <= passes + PW'(1);
                        j               <= '0;
                        k               <= k + PW'(1);
                        swapped_in_pass <= 1'b0;
                    end else begin
                        j <= j1;
                    end
                end
                DRAIN: begin
                    if (out_fire) rd_ptr <= drain_last ? '0 : rd_ptr + PW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_engine.sv
// Scoreboard bench for sort_engine (DEPTH=8 main instance, DEPTH=2 corner instance).
module tb_sort_engine;
    import sort_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 8;
    localparam int unsigned D2 = 2;

    typedef logic [W-1:0] vec_t [D];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sort_engine_if #(.WIDTH(W)) b8 ();
    sort_engine_if #(.WIDTH(W)) b2 ();

    logic                  busy8, done8, busy2, done2;
    logic [swap_w(D)-1:0]  swaps8;
    logic [ptr_w(D)-1:0]   passes8;
    logic [swap_w(D2)-1:0] swaps2;
    logic [ptr_w(D2)-1:0]  passes2;

    sort_engine #(.WIDTH(W), .DEPTH(D)) u_dut8 (
        .clk(clk), .reset(reset), .bus(b8),
        .busy(busy8), .done(done8), .swaps(swaps8), .passes(passes8)
    );

    sort_engine #(.WIDTH(W), .DEPTH(D2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(b2),
        .busy(busy2), .done(done2), .swaps(swaps2), .passes(passes2)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] sb_q [$];

    // Single comparison point.
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference bubble sort with early exit; returns sorted data and cost.
    task automatic model(input vec_t v, input logic d, output vec_t s,
                         output int sw, output int ps, output int cyc);
        logic [W-1:0] t;
        bit any;
        s = v; sw = 0; ps = 0; cyc = 0;
        for (int k = 0; k < int'(D) - 1; k++) begin
            any = 0;
            for (int j = 0; j < int'(D) - 1 - k; j++) begin
                cyc++;
                if (d ? (s[j] < s[j+1]) : (s[j] > s[j+1])) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                    sw++; any = 1;
                end
            end
            ps++;
            if (!any) break;
        end
    endtask

    // Load, sort and drain one vector; abort_at>0 resets on that SORT cycle.
    task automatic run_case(input string tag, input vec_t v, input logic d,
                            input bit toggle, input int abort_at);
        vec_t s;
        int sw, ps, cyc, n, got;
        logic r, have_held;
        logic [W-1:0] held, exp;

        model(v, d, s, sw, ps, cyc);
        sb_q.delete();
        if (abort_at == 0) for (int i = 0; i < int'(D); i++) sb_q.push_back(s[i]);

        for (int i = 0; i < int'(D); i++) begin
            check({tag, "_in_ready_load"}, int'(b8.in_ready), 1);
            b8.in_valid = 1'b1;
            b8.in_data  = v[i];
            b8.desc     = d;
            @(negedge clk);
        end
        b8.in_valid = 1'b0;
        b8.in_data  = 8'hA5;
        b8.desc     = ~d;
        check({tag, "_busy_rise"}, int'(busy8), 1);
        check({tag, "_in_ready_sort"}, int'(b8.in_ready), 0);

        n = 0;
        while (busy8 && n < 200) begin
            n++;
            if (n == abort_at) break;
            @(negedge clk);
        end

        if (abort_at != 0) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check({tag, "_rst_in_ready"}, int'(b8.in_ready), 1);
            check({tag, "_rst_busy"}, int'(busy8), 0);
            check({tag, "_rst_swaps"}, int'(swaps8), 0);
            check({tag, "_rst_passes"}, int'(passes8), 0);
            check({tag, "_rst_out_valid"}, int'(b8.out_valid), 0);
            check({tag, "_rst_out_data"}, int'(b8.out_data), 0);
            return;
        end

        check({tag, "_busy_cycles"}, n, cyc);
        check({tag, "_done"}, int'(done8), 1);
        check({tag, "_out_valid"}, int'(b8.out_valid), 1);
        check({tag, "_swaps"}, int'(swaps8), sw);
        check({tag, "_passes"}, int'(passes8), ps);

        n = 0; got = 0; have_held = 1'b0; held = '0;
        while (got < int'(D) && n < 64) begin
            r = toggle ? ~n[0] : 1'b1;
            if (have_held) check({tag, "_hold"}, int'(b8.out_data), int'(held));
            check({tag, "_in_ready_drain"}, int'(b8.in_ready), 0);
            if (n == 1) check({tag, "_done_pulse"}, int'(done8), 0);
            b8.out_ready = r;
            if (b8.out_valid && r) begin
                exp = sb_q.pop_front();
                check({tag, "_data"}, int'(b8.out_data), int'(exp));
                got++;
            end
            have_held = ~r;
            held      = b8.out_data;
            n++;
            @(negedge clk);
        end
        b8.out_ready = 1'b0;
        check({tag, "_drain_count"}, got, int'(D));
        check({tag, "_in_ready_after"}, int'(b8.in_ready), 1);
        check({tag, "_out_valid_after"}, int'(b8.out_valid), 0);
        check({tag, "_swaps_hold"}, int'(swaps8), sw);
        check({tag, "_passes_hold"}, int'(passes8), ps);
    endtask

    initial begin
        vec_t v;
        logic [W-1:0] exp;
        int n;

        reset = 1'b1;
        b8.in_valid = 1'b0; b8.in_data = '0; b8.desc = 1'b0; b8.out_ready = 1'b0;
        b2.in_valid = 1'b0; b2.in_data = '0; b2.desc = 1'b0; b2.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(b8.in_ready), 1);
        check("rst_out_valid", int'(b8.out_valid), 0);
        check("rst_out_data", int'(b8.out_data), 0);
        check("rst_busy", int'(busy8), 0);
        check("rst_done", int'(done8), 0);
        check("rst_swaps", int'(swaps8), 0);
        check("rst_passes", int'(passes8), 0);
        reset = 1'b0;
        @(negedge clk);

        v = '{8'd4, 8'd5, 8'd1, 8'd3, 8'd2, 8'd6, 8'd8, 8'd7};
        run_case("asc_mix", v, 1'b0, 1'b0, 0);
        run_case("desc_mix", v, 1'b1, 1'b0, 0);
        v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        run_case("sorted", v, 1'b0, 1'b0, 0);
        v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        run_case("reverse", v, 1'b0, 1'b0, 0);
        v = '{8'd3, 8'd3, 8'd1, 8'd1, 8'd2, 8'd2, 8'd0, 8'd0};
        run_case("dups", v, 1'b0, 1'b1, 0);
        v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        run_case("abort", v, 1'b0, 1'b0, 5);
        for (int i = 0; i < int'(D); i++) v[i] = W'($urandom_range(0, 255));
        run_case("fresh_rand", v, 1'b1, 1'b1, 0);
        v = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd128, 8'd128, 8'd1, 8'd254};
        run_case("extremes", v, 1'b0, 1'b0, 0);

        // DEPTH=2 instance: 2,1 ascending needs exactly one swap.
        sb_q.delete();
        sb_q.push_back(8'd1);
        sb_q.push_back(8'd2);
        b2.in_valid = 1'b1; b2.in_data = 8'd2; b2.desc = 1'b0;
        @(negedge clk);
        b2.in_data = 8'd1;
        @(negedge clk);
        b2.in_valid = 1'b0;
        check("d2_busy", int'(busy2), 1);
        @(negedge clk);
        check("d2_done", int'(done2), 1);
        check("d2_swaps", int'(swaps2), 1);
        check("d2_passes", int'(passes2), 1);
        n = 0;
        while (sb_q.size() > 0 && n < 16) begin
            b2.out_ready = 1'b1;
            if (b2.out_valid) begin
                exp = sb_q.pop_front();
                check("d2_data", int'(b2.out_data), int'(exp));
            end
            n++;
            @(negedge clk);
        end
        b2.out_ready = 1'b0;
        check("d2_drain_left", sb_q.size(), 0);
        check("d2_in_ready_after", int'(b2.in_ready), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
